// File: rtl/parity_rx.sv
// parity_rx: start/data/parity/stop serial receiver clocked by a bit_en strobe.
// Define PARITY_RX_ERR_CNT_EN to add a saturating error counter (cnt_clr, err_cnt).
module parity_rx #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_in,
`ifdef PARITY_RX_ERR_CNT_EN
    input  logic              cnt_clr,
    output logic [7:0]        err_cnt,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              par_err,
    output logic              frm_err,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d, data_q, data_d;
    logic                par_rx_q, par_rx_d;
    logic                valid_q, valid_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_rx_d  = par_rx_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        valid_d   = 1'b0;
        frm_err_d = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: if (!rx_in) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    for (int i = 0; i < DATA_W; i++)
                        if (cnt_q == CNT_W'(i)) shift_d[i] = rx_in;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) state_d = PARITY;
                end
                PARITY: begin
                    par_rx_d = rx_in;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (rx_in) begin
                        data_d    = shift_q;
                        par_err_d = par_rx_q ^ (^shift_q);
                        valid_d   = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_rx_q  <= 1'b0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            valid_q   <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_rx_q  <= par_rx_d;
            data_q    <= data_d;
            par_err_q <= par_err_d;
            valid_q   <= valid_d;
            frm_err_q <= frm_err_d;
        end
    end
    assign data_out = data_q;
    assign valid    = valid_q;
    assign par_err  = par_err_q;
    assign frm_err  = frm_err_q;
    assign busy     = state_q != IDLE;
`ifdef PARITY_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_inc;
    // counts the registered error pulses, so it lags them by one cycle
    always_comb begin
        err_inc   = (valid_q && par_err_q) || frm_err_q;
        err_cnt_d = cnt_clr ? 8'd0 : (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 8'd0;
        else        err_cnt_q <= err_cnt_d;
    end
    assign err_cnt = err_cnt_q;
`endif
endmodule
